// File: rtl/ul_reg_bank_mc_pkg.sv
// Shared address map and helpers for the multi-channel UL register bank.
// Global registers sit in 0x000-0x00F; channel c occupies 0x010 + 8*c.
package ul_reg_bank_mc_pkg;

  localparam logic [7:0] ADDR_VER_TIME = 8'h00;
  localparam logic [7:0] ADDR_VER_TYPE = 8'h01;
  localparam logic [7:0] ADDR_CH_NUM   = 8'h02;
  localparam logic [7:0] ADDR_VLED     = 8'h03;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h04;
  localparam logic [7:0] ADDR_RD_CNT   = 8'h05;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h06;

  // Channel blocks are 8 words wide, so addr[7:3] selects the block; 0x010 is block 2.
  localparam logic [4:0] CH_BASE_BLK = 5'd2;

  typedef enum logic [2:0] {
    OFS_OPA        = 3'd0,
    OFS_OPB        = 3'd1,
    OFS_SUM        = 3'd2,
    OFS_TMOUT      = 3'd3,
    OFS_ERR_STICKY = 3'd4,
    OFS_ERR_CNT    = 3'd5
  } ch_ofs_e;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ul_reg_ch.sv
// One channel: operand registers with a pipelined sum, timeout cfg,
// sticky error flags and a saturating rising-edge error counter.
module ul_reg_ch
  import ul_reg_bank_mc_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ERR_WIDTH  = 2,
  parameter logic [15:0] TMOUT_INIT = 16'hFFFF
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [2:0]            ofs,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ERR_WIDTH-1:0]  err_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           tmout,
  output logic                  has_err
);

  logic [DATA_WIDTH-1:0] opa_reg;
  logic [DATA_WIDTH-1:0] opb_reg;
  logic [DATA_WIDTH-1:0] sum_reg;
  logic [15:0]           tmout_reg;
  logic [ERR_WIDTH-1:0]  sticky_reg;
  logic [ERR_WIDTH-1:0]  err_prev_reg;
  logic [15:0]           cnt_reg;
  logic [ERR_WIDTH-1:0]  w1c_mask;
  logic                  err_rise;

  assign w1c_mask = (wr && ofs == OFS_ERR_STICKY) ? wr_data[ERR_WIDTH-1:0] : '0;
  assign err_rise = |(err_in & ~err_prev_reg);

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      opa_reg      <= '0;
      opb_reg      <= '0;
      sum_reg      <= '0;
      tmout_reg    <= TMOUT_INIT;
      sticky_reg   <= '0;
      err_prev_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      // Operand registers form stage 1, sum_reg stage 2.
      sum_reg <= opa_reg + opb_reg;
      if (wr && ofs == OFS_OPA)   opa_reg   <= wr_data;
      if (wr && ofs == OFS_OPB)   opb_reg   <= wr_data;
      if (wr && ofs == OFS_TMOUT) tmout_reg <= wr_data[15:0];
      // OR-ing the live level after the clear lets a held error win over W1C.
      sticky_reg   <= (sticky_reg & ~w1c_mask) | err_in;
      err_prev_reg <= err_in;
      if (wr && ofs == OFS_ERR_CNT) cnt_reg <= err_rise ? 16'd1 : 16'd0;
      else if (err_rise)            cnt_reg <= sat_inc16(cnt_reg);
    end
  end

  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_OPA:        rd_data = opa_reg;
      OFS_OPB:        rd_data = opb_reg;
      OFS_SUM:        rd_data = sum_reg;
      OFS_TMOUT:      rd_data = DATA_WIDTH'(tmout_reg);
      OFS_ERR_STICKY: rd_data = DATA_WIDTH'(sticky_reg);
      OFS_ERR_CNT:    rd_data = DATA_WIDTH'(cnt_reg);
      default:        rd_data = '0;
    endcase
  end

  assign tmout   = tmout_reg;
  assign has_err = |sticky_reg;

endmodule

// File: rtl/ul_reg_bank_mc.sv
// Multi-channel UL register bank: global registers, channel decode,
// registered read port with valid pulse, and the maskable error interrupt.
module ul_reg_bank_mc
  import ul_reg_bank_mc_pkg::*;
#(
  parameter int          CPU_ADDR_WIDTH = 12,
  parameter int          CPU_DATA_WIDTH = 32,
  parameter int          CH_NUM         = 4,
  parameter int          ERR_WIDTH      = 2,
  parameter logic [31:0] VER_TIME       = 32'h2018_0301,
  parameter logic [31:0] VER_TYPE       = 32'h00D3_0007,
  parameter logic [15:0] TMOUT_INIT     = 16'hFFFF
) (
  input  logic                          clks,
  input  logic                          reset,
  input  logic                          cpu_wr,
  input  logic [CPU_ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [CPU_DATA_WIDTH-1:0]     cpu_data_in,
  input  logic                          cpu_rd,
  output logic [CPU_DATA_WIDTH-1:0]     cpu_data_out,
  output logic                          cpu_rd_vld,
  input  logic [CH_NUM*ERR_WIDTH-1:0]   ch_err_in,
  output logic [CH_NUM*16-1:0]          reg_tmout_us_cfg,
  output logic [15:0]                   ul2sh_vled,
  output logic                          err_irq
);

  logic [15:0]               vled_reg;
  logic [CPU_DATA_WIDTH-1:0] scratch_reg;
  logic [31:0]               rd_cnt_reg;
  logic [CH_NUM-1:0]         irq_mask_reg;

  logic                      upper_zero;
  logic [7:0]                addr_lo;
  logic [4:0]                blk;
  logic [4:0]                ch_sel;
  logic                      ch_hit;
  logic [CPU_DATA_WIDTH-1:0] ch_rd_data [CH_NUM];
  logic [CH_NUM-1:0]         ch_has_err;
  logic [CPU_DATA_WIDTH-1:0] rd_mux;

  // Anything above 0x0FF is unmapped, so the upper address bits must be zero.
  assign upper_zero = (cpu_addr >> 8) == '0;
  assign addr_lo    = cpu_addr[7:0];
  assign blk        = cpu_addr[7:3];
  assign ch_sel     = blk - CH_BASE_BLK;
  assign ch_hit     = upper_zero && (blk >= CH_BASE_BLK) && (ch_sel < 5'(CH_NUM));

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      ul_reg_ch #(
        .DATA_WIDTH (CPU_DATA_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH),
        .TMOUT_INIT (TMOUT_INIT)
      ) u_ch (
        .clks    (clks),
        .reset   (reset),
        .wr      (cpu_wr && ch_hit && (ch_sel == 5'(gi))),
        .ofs     (cpu_addr[2:0]),
        .wr_data (cpu_data_in),
        .err_in  (ch_err_in[gi*ERR_WIDTH +: ERR_WIDTH]),
        .rd_data (ch_rd_data[gi]),
        .tmout   (reg_tmout_us_cfg[gi*16 +: 16]),
        .has_err (ch_has_err[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    if (upper_zero) begin
      case (addr_lo)
        ADDR_VER_TIME: rd_mux = CPU_DATA_WIDTH'(VER_TIME);
        ADDR_VER_TYPE: rd_mux = CPU_DATA_WIDTH'(VER_TYPE);
        ADDR_CH_NUM:   rd_mux = CPU_DATA_WIDTH'(CH_NUM);
        ADDR_VLED:     rd_mux = CPU_DATA_WIDTH'(vled_reg);
        ADDR_SCRATCH:  rd_mux = ~scratch_reg;
        ADDR_RD_CNT:   rd_mux = CPU_DATA_WIDTH'(rd_cnt_reg);
        ADDR_IRQ_MASK: rd_mux = CPU_DATA_WIDTH'(irq_mask_reg);
        default:       rd_mux = '0;
      endcase
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_hit && ch_sel == 5'(i)) rd_mux = ch_rd_data[i];
    end
  end

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      cpu_data_out <= '0;
      cpu_rd_vld   <= 1'b0;
      err_irq      <= 1'b0;
      vled_reg     <= '0;
      scratch_reg  <= '0;
      rd_cnt_reg   <= '0;
      irq_mask_reg <= '0;
    end else begin
      cpu_rd_vld <= cpu_rd;
      // The mux sees pre-write state, so a same-cycle write is not visible to the read.
      if (cpu_rd) cpu_data_out <= rd_mux;
      if (cpu_rd && upper_zero && addr_lo == ADDR_RD_CNT) rd_cnt_reg <= rd_cnt_reg + 32'd1;
      if (cpu_wr && upper_zero) begin
        if (addr_lo == ADDR_VLED)     vled_reg     <= cpu_data_in[15:0];
        if (addr_lo == ADDR_SCRATCH)  scratch_reg  <= cpu_data_in;
        if (addr_lo == ADDR_IRQ_MASK) irq_mask_reg <= cpu_data_in[CH_NUM-1:0];
      end
      err_irq <= |(ch_has_err & irq_mask_reg);
    end
  end

  assign ul2sh_vled = vled_reg;

endmodule
